// File: rtl/fun_pkg.sv
// Shared definitions for the function-unit sweep controller: FSM encoding,
// vector geometry and the golden truth table of fun.
package fun_pkg;

  localparam int NI = 3;
  localparam int NV = 8;

  localparam logic [NV-1:0] FUN_TT = 8'h39;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_APPLY  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;

  typedef logic [NI-1:0] vec_t;

  // Index of the lowest set bit; zero when nothing is set.
  function automatic vec_t lowest_set(input logic [NV-1:0] m);
    lowest_set = '0;
    for (int i = NV - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = i[NI-1:0];
    end
  endfunction

endpackage

// File: rtl/fun.sv
// Three-input combinational function unit under test.
module fun (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);

  assign y = (a & ~b) | (~b & ~c) | (~a & b & c);

endmodule

// File: rtl/fun_sweep_ctrl.sv
// Built-in self-test sequencer: walks {a,b,c} through all eight vectors,
// builds the truth table of fun and compares it with a start-time expected table.
module fun_sweep_ctrl
  import fun_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [NV-1:0] exp_tt,
  output logic          a_o,
  output logic          b_o,
  output logic          c_o,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [NV-1:0] tt,
  output logic [NV-1:0] mismatch,
  output vec_t          fail_idx
);

  logic [2:0]    state;
  vec_t          idx;
  logic [3:0]    cnt;
  logic [NV-1:0] exp_q;
  logic [NV-1:0] work_tt;
  logic          y;

  fun u_fun (
    .a (a_o),
    .b (b_o),
    .c (c_o),
    .y (y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      cnt      <= '0;
      exp_q    <= '0;
      work_tt  <= '0;
      a_o      <= 1'b0;
      b_o      <= 1'b0;
      c_o      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      tt       <= '0;
      mismatch <= '0;
      fail_idx <= '0;
    end else begin
      done <= 1'b0;
      if (abort && state != S_IDLE) begin
        // Cancel discards the partial table; committed results are untouched.
        state           <= S_IDLE;
        busy            <= 1'b0;
        idx             <= '0;
        cnt             <= '0;
        {a_o, b_o, c_o} <= 3'b000;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              exp_q   <= exp_tt;
              idx     <= '0;
              work_tt <= '0;
              busy    <= 1'b1;
              state   <= S_APPLY;
            end
          end
          S_APPLY: begin
            {a_o, b_o, c_o} <= idx;
            cnt             <= 4'(SETTLE);
            state           <= S_WAIT;
          end
          S_WAIT: begin
            // WAIT always occupies at least one cycle, SETTLE cycles otherwise.
            if (cnt <= 4'd1) state <= S_SAMPLE;
            else             cnt   <= cnt - 4'd1;
          end
          S_SAMPLE: begin
            work_tt[idx] <= y;
            if (idx == vec_t'(NV - 1)) begin
              state <= S_CHECK;
            end else begin
              idx   <= idx + vec_t'(1);
              state <= S_APPLY;
            end
          end
          S_CHECK: begin
            tt              <= work_tt;
            mismatch        <= work_tt ^ exp_q;
            pass            <= (work_tt == exp_q);
            fail_idx        <= lowest_set(work_tt ^ exp_q);
            done            <= 1'b1;
            busy            <= 1'b0;
            {a_o, b_o, c_o} <= 3'b000;
            state           <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fun_sweep_ctrl.sv
// Randomized self-checking bench for fun_sweep_ctrl against a truth-table model.
module tb_fun_sweep_ctrl;
  import fun_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic [7:0] exp_tt;
  logic       a_o, b_o, c_o, busy, done, pass;
  logic [7:0] tt, mismatch;
  logic [2:0] fail_idx;

  int tests = 0;
  int fails = 0;

  logic [7:0] last_tt, last_mis;
  logic       last_pass;
  logic [2:0] last_fidx;

  fun_sweep_ctrl #(.SETTLE(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .exp_tt   (exp_tt),
    .a_o      (a_o),
    .b_o      (b_o),
    .c_o      (c_o),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .tt       (tt),
    .mismatch (mismatch),
    .fail_idx (fail_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Truth table straight from the boolean equation.
  function automatic logic [7:0] ref_tt();
    logic [7:0] t;
    for (int i = 0; i < 8; i++) begin
      bit a, b, c;
      a = ((i >> 2) & 1) != 0;
      b = ((i >> 1) & 1) != 0;
      c = (i & 1) != 0;
      t[i] = (a && !b) || (!b && !c) || (!a && b && c);
    end
    return t;
  endfunction

  function automatic logic [2:0] ref_first(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic set_expect(input logic [7:0] e);
    last_tt   = ref_tt();
    last_mis  = last_tt ^ e;
    last_pass = (last_mis == 8'h00);
    last_fidx = ref_first(last_mis);
  endtask

  task automatic chk_results(input string tag);
    chk({tag, "_tt"}, tt, last_tt);
    chk({tag, "_pass"}, pass, last_pass);
    chk({tag, "_mis"}, mismatch, last_mis);
    chk({tag, "_fidx"}, fail_idx, last_fidx);
  endtask

  // One full sweep; with noise, start pulses and exp_tt changes are thrown in mid-sweep.
  task automatic sweep(input logic [7:0] e, input bit noise);
    logic [2:0] vq[$];
    logic [2:0] v;
    int lat;
    lat = -1;
    @(negedge clk);
    start  = 1'b1;
    exp_tt = e;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      v = {a_o, b_o, c_o};
      if (vq.size() == 0 || v != vq[vq.size()-1]) vq.push_back(v);
      if (noise) begin
        start  = ($urandom_range(0, 3) == 0);
        exp_tt = 8'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    set_expect(e);
    chk("latency", lat, 25);
    chk("vec_count", vq.size(), 8);
    for (int i = 0; i < 8; i++)
      chk("vec_order", (i < vq.size()) ? 32'(vq[i]) : 32'hFFFF, i);
    chk("busy_after", busy, 0);
    chk_results("sweep");
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask

  initial begin
    int dcount, d0, d1;
    logic [7:0] ea, eb;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; exp_tt = 8'h00;
    #23;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_vec", {a_o, b_o, c_o}, 0);
    chk("rst_tt", tt, 0);
    chk("rst_pass", pass, 0);
    chk("rst_mis", mismatch, 0);
    chk("rst_fidx", fail_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;

    sweep(8'h39, 1'b0);
    sweep(8'h3B, 1'b0);
    sweep(8'hC6, 1'b0);
    for (int r = 0; r < 4; r++) sweep(8'($urandom), 1'b1);

    // start and abort together in idle: abort wins
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    @(negedge clk);
    chk("idle_abort_busy2", busy, 0);

    // aborts at cycle 10 and at random points
    for (int r = 0; r < 3; r++) begin
      int k;
      k = (r == 0) ? 10 : $urandom_range(1, 23);
      @(negedge clk); start = 1'b1; exp_tt = 8'($urandom);
      @(negedge clk); start = 1'b0;
      repeat (k - 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_vec", {a_o, b_o, c_o}, 0);
      dcount = 0;
      repeat (40) begin
        @(negedge clk);
        if (done) dcount++;
      end
      chk("abort_nodone", dcount, 0);
      chk_results("abort_keep");
    end

    // start held high: back-to-back sweeps, each using its own accept-time exp_tt
    ea = 8'h39; eb = 8'h3B;
    dcount = 0; d0 = -1; d1 = -1;
    @(negedge clk); start = 1'b1; exp_tt = ea;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (n == 5) exp_tt = eb;
      if (done) begin
        set_expect((dcount == 0) ? ea : eb);
        chk_results("b2b");
        if (dcount == 0) d0 = n; else d1 = n;
        dcount++;
      end
    end
    start = 1'b0;
    chk("b2b_count", dcount, 2);
    chk("b2b_first", d0, 25);
    chk("b2b_spacing", d1 - d0, 26);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("b2b_abort_busy", busy, 0);

    // asynchronous reset in the middle of a sweep
    @(negedge clk); start = 1'b1; exp_tt = 8'h39;
    @(negedge clk); start = 1'b0;
    repeat (11) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_vec", {a_o, b_o, c_o}, 0);
    chk("mrst_tt", tt, 0);
    chk("mrst_pass", pass, 0);
    chk("mrst_mis", mismatch, 0);
    @(negedge clk); rst_n = 1'b1;
    dcount = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("mrst_nodone", dcount, 0);
    sweep(8'h39, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
